mmac_result_serializer: RTL and testbench

- Reader side of the packed matrix result bus produced by the matrix accumulate stage.
- Accepts one packed M_SIZE x M_SIZE result word through a valid/ready handshake.
- Streams the elements out one per cycle, in row-major order, with row/col tags and a last flag.
- Feeds downstream narrow consumers such as memory writeback or a debug UART.

---
 rtl/mmac_pkg.sv | 23 ++
 rtl/mmac_result_serializer_if.sv | 29 ++
 rtl/mmac_result_serializer.sv | 94 +++++++++
 tb/tb_mmac_result_serializer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmac_pkg.sv
// Shared constants, types and helpers for the matrix accumulate result path.
package mmac_pkg;

  localparam int M_SIZE     = 4;
  localparam int VAR_WIDTH  = 8;
  localparam int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH;
  localparam int ELEMS      = M_SIZE * M_SIZE;
  localparam int IDX_W      = $clog2(M_SIZE);
  localparam int CNT_W      = $clog2(ELEMS);

  typedef logic [VAR_WIDTH-1:0] elem_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_e;

  // Element 0 sits in the most significant slice; row-major order.
  function automatic elem_t elem_at(input logic [DATA_WIDTH-1:0] word, input int unsigned e);
    return elem_t'(word >> ((ELEMS - 1 - e) * VAR_WIDTH));
  endfunction

endpackage

// File: rtl/mmac_result_serializer_if.sv
// Packed-result input handshake and per-element output stream of the serializer.
interface mmac_result_serializer_if #(
  parameter int M_SIZE    = mmac_pkg::M_SIZE,
  parameter int VAR_WIDTH = mmac_pkg::VAR_WIDTH
);
  localparam int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH;
  localparam int IDX_W      = $clog2(M_SIZE);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [VAR_WIDTH-1:0]  out_data;
  logic [IDX_W-1:0]      out_row;
  logic [IDX_W-1:0]      out_col;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last
  );

endinterface

// File: rtl/mmac_result_serializer.sv
// Streams one packed M_SIZE x M_SIZE result out element by element, row-major, with tags.
// Optional MMAC_SER_BACK_TO_BACK_EN lets the next matrix load on the final transfer (no bubble).
//
// state  | meaning
// S_IDLE | waiting for a packed result, in_ready high
// S_SEND | presenting element cnt_q from the top of the shift register
module mmac_result_serializer #(
  parameter int M_SIZE    = mmac_pkg::M_SIZE,
  parameter int VAR_WIDTH = mmac_pkg::VAR_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  mmac_result_serializer_if.slave  bus,
  output logic                     busy
);
  import mmac_pkg::*;

  localparam int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH;
  localparam int ELEMS      = M_SIZE * M_SIZE;
  localparam int IDX_W      = $clog2(M_SIZE);
  localparam int CNT_W      = $clog2(ELEMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ELEMS - 1);
  localparam logic [CNT_W-1:0] M_CNT    = CNT_W'(M_SIZE);

  ser_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last;
  logic                  xfer;
  logic                  accept;

  assign last = (state_q == S_SEND) && (cnt_q == LAST_CNT);
  assign xfer = bus.out_valid && bus.out_ready;

`ifdef MMAC_SER_BACK_TO_BACK_EN
  assign bus.in_ready = !reset && ((state_q == S_IDLE) || (last && bus.out_ready));
`else
  assign bus.in_ready = !reset && (state_q == S_IDLE);
`endif

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d = bus.in_data;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // A load here can only coincide with the final transfer, so it replaces it.
        if (accept) begin
          shreg_d = bus.in_data;
          cnt_d   = '0;
          state_d = S_SEND;
        end else if (xfer) begin
          shreg_d = shreg_q << VAR_WIDTH;
          if (last) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q == S_SEND);
  assign bus.out_data  = shreg_q[DATA_WIDTH-1 -: VAR_WIDTH];
  assign bus.out_row   = IDX_W'(cnt_q / M_CNT);
  assign bus.out_col   = IDX_W'(cnt_q % M_CNT);
  assign bus.out_last  = last;
  assign busy          = (state_q == S_SEND);

endmodule

// File: tb/tb_mmac_result_serializer.sv
// Scoreboard bench for mmac_result_serializer: directed matrices, backpressure, reset, back-to-back.
module tb_mmac_result_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } exp_t;

`ifdef MMAC_SER_BACK_TO_BACK_EN
  localparam int GAP_SPAN = 32;
  localparam int EXP_GAPS = 0;
`else
  localparam int GAP_SPAN = 33;
  localparam int EXP_GAPS = 1;
`endif

  localparam logic [127:0] MAT_A  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] MAT_B  = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] MAT_AA = {16{8'hAA}};
  localparam logic [127:0] MAT_FF = {128{1'b1}};

  logic clock = 1'b0;
  logic reset;
  logic busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  mmac_result_serializer_if bus ();

  mmac_result_serializer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] base, input bit inc);
    exp_t x;
    for (int e = 0; e < 16; e++) begin
      x.data = inc ? base + 8'(e) : base;
      x.row  = 2'(e / 4);
      x.col  = 2'(e % 4);
      x.last = (e == 15);
      sb.push_back(x);
    end
  endtask

  // Returns one time-step after the accepting rising edge.
  task automatic send_matrix(input logic [127:0] d);
    bit ok;
    ok = 0;
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        ok = 1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (sb.size() == 0) break;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops on every accepted element, and checks outputs hold while stalled.
  exp_t cur, held, e_pop;
  bit   hold_v = 0;
  initial begin
    forever begin
      @(negedge clock);
      cur = '{bus.out_data, bus.out_row, bus.out_col, bus.out_last};
      if (reset) begin
        hold_v = 0;
      end else begin
        if (hold_v) check("stall_hold", {bus.out_valid, cur}, {1'b1, held});
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_elem: got %0h expected none", cur);
          end else begin
            e_pop = sb.pop_front();
            check("elem", 64'(cur), 64'(e_pop));
          end
        end
        hold_v = bus.out_valid && !bus.out_ready;
        held   = cur;
      end
    end
  end

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit vseq [36];

  initial begin
    int nv, ones, zeros;
    bit acc;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_tags", {bus.out_data, bus.out_row, bus.out_col, bus.out_last}, 64'd0);

    // Basic stream, out_ready held high
    push_expected(8'h00, 1);
    bus.out_ready = 1'b1;
    send_matrix(MAT_A);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (bus.out_valid) nv++;
    end
    check("basic_valid_run", 64'(nv), 64'd16);
    @(negedge clock);
    check("basic_idle_valid", 64'(bus.out_valid), 64'd0);
    check("basic_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("basic_drain", 64'(sb.size()), 64'd0);

    // Backpressure with a rejected mid-stream offer
    push_expected(8'h00, 1);
    send_matrix(MAT_A);
    for (int i = 0; i < 200; i++) begin
      bus.out_ready = pat[i % 4];
      bus.in_valid  = (i == 5);
      if (i == 5) bus.in_data = MAT_FF;
      @(negedge clock);
      if (i == 5) check("bp_no_accept", 64'(bus.in_ready), 64'd0);
      @(posedge clock); #1;
      if (sb.size() == 0) break;
    end
    bus.in_valid = 1'b0;
    check("bp_drain", 64'(sb.size()), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("bp_idle_valid", 64'(bus.out_valid), 64'd0);
    check("bp_idle_busy", 64'(busy), 64'd0);

    // Reset after element 0x05 transfers
    push_expected(8'h00, 1);
    send_matrix(MAT_A);
    repeat (6) @(posedge clock);
    #1;
    check("rst_mid_remaining", 64'(sb.size()), 64'd10);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    push_expected(8'hAA, 0);
    send_matrix(MAT_AA);
    wait_drain(40, "rst_aa_drain");

    // Back-to-back matrices with out_ready high
    push_expected(8'h00, 1);
    push_expected(8'h10, 1);
    send_matrix(MAT_A);
    bus.in_valid = 1'b1;
    bus.in_data  = MAT_B;
    for (int c = 0; c < 36; c++) begin
      @(negedge clock);
      vseq[c] = bus.out_valid;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clock); #1;
      if (acc) bus.in_valid = 1'b0;
    end
    check("b2b_second_accepted", 64'(bus.in_valid), 64'd0);
    bus.in_valid = 1'b0;
    ones = 0;
    zeros = 0;
    for (int c = 0; c < GAP_SPAN; c++) begin
      if (vseq[c]) ones++;
      else zeros++;
    end
    check("b2b_valid_cycles", 64'(ones), 64'd32);
    check("b2b_gaps", 64'(zeros), 64'(EXP_GAPS));
    check("b2b_end_idle", 64'(vseq[GAP_SPAN]), 64'd0);
    check("b2b_drain", 64'(sb.size()), 64'd0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
